// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction-fetch front end sitting directly upstream of the IF/ID register.
//   It owns the fetch PC and issues in-order requests to an instruction memory
//   that uses a req/gnt/rvalid handshake and has variable latency. Returned
//   instructions are buffered in a small FIFO, and the head entry is presented
//   to decode. A redirect restarts fetch at a new PC. Any response still in
//   flight at that point is discarded when it arrives.
//
// Ports
//   clk, reset_n              system clock (rising edge), async active-low reset
//   imem_req / imem_addr      request valid and word-aligned fetch address
//   imem_gnt                  request accepted this cycle
//   imem_rvalid / imem_rdata  in-order response valid and instruction data
//   redirect / redirect_pc    one-cycle pulse restarting fetch at redirect_pc
//   stallD                    decode stalled; head is not consumed
//   InstrF / PCPlus4F         head instruction and its address + 4 (0 when empty)
//   validF                    FIFO non-empty
module fetch_queue_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stallD,
    output logic [31:0] InstrF,
    output logic [31:0] PCPlus4F,
    output logic        validF
);
    localparam int          PW        = $clog2(QDEPTH);
    localparam int          CW        = $clog2(QDEPTH + 1);
    localparam int          OW        = $clog2(MAX_OUT + 1);
    localparam int          SW        = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [31:0] QDEPTH_U  = 32'(QDEPTH);
    localparam logic [31:0] MAX_OUT_U = 32'(MAX_OUT);

    logic [31:0]   r_fpc;
    logic          r_run;
    logic [OW-1:0] r_out_cnt;
    logic [OW-1:0] r_drop_cnt;
    logic [31:0]   r_q_instr [QDEPTH];
    logic [31:0]   r_q_pc4   [QDEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_sh_addr [MAX_OUT];
    logic [SW-1:0] r_sh_wr;
    logic [SW-1:0] r_sh_rd;

    logic        w_hs;
    logic        w_rsp;
    logic        w_drop;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_credit;

    function automatic logic [SW-1:0] sh_inc(input logic [SW-1:0] p);
        return (p == SW'(MAX_OUT - 1)) ? '0 : p + SW'(1);
    endfunction

    // FIFO slots already spoken for: held entries plus live (non-dropped) requests.
    assign w_credit  = 32'(r_count) + 32'(r_out_cnt) - 32'(r_drop_cnt);

    // r_run holds off the first request until the first edge after reset release.
    assign imem_req  = r_run & ~redirect & (32'(r_out_cnt) < MAX_OUT_U) & (w_credit < QDEPTH_U);
    assign imem_addr = r_fpc;

    assign w_hs   = imem_req & imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp  = imem_rvalid & (r_out_cnt != '0);
    // A response arriving in the redirect cycle is stale as well.
    assign w_drop = redirect | (r_drop_cnt != '0);
    assign w_push = w_rsp & ~w_drop;

    assign validF   = (r_count != '0);
    assign w_pop    = validF & ~stallD & ~redirect;
    assign InstrF   = validF ? r_q_instr[r_rd_ptr] : 32'h0;
    assign PCPlus4F = validF ? r_q_pc4[r_rd_ptr]   : 32'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run      <= 1'b0;
            r_fpc      <= {RESET_PC[31:2], 2'b00};
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_sh_wr    <= '0;
            r_sh_rd    <= '0;
        end else begin
            r_run     <= 1'b1;
            r_out_cnt <= r_out_cnt + OW'(w_hs) - OW'(w_rsp);
            if (redirect) begin
                // Every request still outstanding after this cycle is stale.
                r_fpc      <= {redirect_pc[31:2], 2'b00};
                r_drop_cnt <= r_out_cnt - OW'(w_rsp);
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_hs)
                    r_fpc <= r_fpc + 32'd4;
                if (w_rsp && (r_drop_cnt != '0))
                    r_drop_cnt <= r_drop_cnt - OW'(1);
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
            // The address shadow tracks every request, dropped or not, so it stays aligned.
            if (w_hs)
                r_sh_wr <= sh_inc(r_sh_wr);
            if (w_rsp)
                r_sh_rd <= sh_inc(r_sh_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_pc4[r_wr_ptr]   <= r_sh_addr[r_sh_rd] + 32'd4;
        end
        if (w_hs)
            r_sh_addr[r_sh_wr] <= r_fpc;
    end

    a_rvalid_protocol: assert property (@(posedge clk) disable iff (!reset_n)
        !(imem_rvalid && (r_out_cnt == '0)));

    a_fifo_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_push && !w_pop && (r_count == CW'(QDEPTH))));

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;
    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stallD;
    logic [31:0] InstrF;
    logic [31:0] PCPlus4F;
    logic        validF;

    fetch_queue_unit #(.RESET_PC(32'h0), .QDEPTH(2), .MAX_OUT(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stallD(stallD),
        .InstrF(InstrF), .PCPlus4F(PCPlus4F), .validF(validF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Scoreboard of fetch addresses expected to be consumed by decode, in order.
    logic [31:0] sb[$];

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } rsp_t;
    rsp_t mq[$];
    int   cyc      = 0;
    int   hs_total = 0;
    int   lat      = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req)
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_range(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++)
            sb.push_back(start + 32'(4 * i));
    endtask

    task automatic grant_to(input int target);
        int k;
        imem_gnt = 1'b1;
        for (k = 0; k < 60; k++) begin
            tick();
            if (hs_total >= target) break;
        end
        imem_gnt = 1'b0;
        if (k == 60) begin
            n_chk++;
            $display("FAIL grant_timeout: got %0d handshakes, required %0d", hs_total, target);
        end
    endtask

    task automatic grant_n(input int n);
        grant_to(hs_total + n);
    endtask

    task automatic drain();
        int k;
        imem_gnt = 1'b0;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!validF && !imem_rvalid && mq.size() == 0) break;
        end
        tick();
        if (k == 60) begin
            n_chk++;
            $display("FAIL drain_timeout: got validF=%b, required 0", validF);
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    // Memory model: in-order responses, latency 'lat' cycles after the grant edge.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (reset_n && imem_req && imem_gnt) begin
                mq.push_back('{addr: imem_addr, ready: cyc + lat});
                hs_total++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!reset_n) begin
                mq.delete();
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end else if (mq.size() > 0 && mq[0].ready <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hE000_0000 + mq[0].addr;
                void'(mq.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    end

    // Monitor: every instruction consumed by decode must be the next expected one.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (reset_n && validF && !stallD && !redirect) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL pop_unexpected: got pc4=%h instr=%h, required no entry", PCPlus4F, InstrF);
            end else begin
                e = sb.pop_front();
                chk("pop_pcplus4", PCPlus4F, e + 32'd4);
                chk("pop_instr", InstrF, 32'hE000_0000 + e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        reset_n     = 1'b0;
        imem_gnt    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stallD      = 1'b0;

        // Reset state
        #2;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_validF", 32'(validF), 32'd0);
        chk("rst_instr", InstrF, 32'h0);
        chk("rst_pc4", PCPlus4F, 32'h0);

        // Stream from RESET_PC, 1-cycle latency
        expect_range(32'h0, 8);
        tick();
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("first_req_held", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (validF) break;
        end
        chk("first_valid_latency", 32'(k), 32'd2);
        grant_to(8);
        drain();

        // Grant held low: address holds, then advances exactly once per grant
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nognt_req", 32'(imem_req), 32'd1);
            chk("nognt_addr", imem_addr, 32'h20);
        end
        tick();
        sb.push_back(32'h20);
        grant_n(1);
        @(negedge clk);
        chk("one_grant_addr", imem_addr, 32'h24);
        drain();

        // Decode stall: FIFO fills, requests stop, head holds
        expect_range(32'h24, 6);
        base     = hs_total;
        stallD   = 1'b1;
        imem_gnt = 1'b1;
        repeat (6) tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_validF", 32'(validF), 32'd1);
            chk("stall_instr", InstrF, 32'hE000_0024);
            chk("stall_pc4", PCPlus4F, 32'h28);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        chk("stall_grants", 32'(hs_total - base), 32'd2);
        tick();
        stallD = 1'b0;
        grant_to(base + 6);
        drain();

        // Redirect with two requests in flight: both discarded
        redirect    = 1'b1;
        redirect_pc = 32'h10;
        @(negedge clk);
        chk("redir_noreq_a", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        lat      = 4;
        grant_n(2);
        expect_range(32'h100, 2);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        chk("redir_noreq_b", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("redir_addr", imem_addr, 32'h100);
        tick();
        grant_n(2);
        drain();

        // Redirect coinciding with the response of the last outstanding request
        lat = 3;
        grant_n(1);
        tick();
        tick();
        sb.push_back(32'h100);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        chk("redir_rv_noreq", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("redir_rv_req", 32'(imem_req), 32'd1);
        chk("redir_rv_addr", imem_addr, 32'h100);
        tick();
        grant_n(1);
        drain();

        // Reset asserted between edges mid-stream
        lat = 1;
        expect_range(32'h104, 12);
        imem_gnt = 1'b1;
        repeat (7) tick();
        @(negedge clk);
        #2;
        reset_n  = 1'b0;
        imem_gnt = 1'b0;
        #1;
        chk("midrst_validF", 32'(validF), 32'd0);
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_instr", InstrF, 32'h0);
        sb.delete();
        tick();
        tick();
        reset_n = 1'b1;
        expect_range(32'h0, 2);
        @(negedge clk);
        chk("postrst_validF", 32'(validF), 32'd0);
        chk("postrst_req_held", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("postrst_req", 32'(imem_req), 32'd1);
        chk("postrst_addr", imem_addr, 32'h0);
        tick();
        grant_n(2);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Instruction-fetch front end directly upstream of the IF/ID register.
- Owns the fetch PC and issues in-order requests to an instruction memory with variable latency and a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO and presents the head as InstrF with PCPlus4F.
- Honours stallD from the hazard unit. Redirects on a taken branch or PC write, and discards in-flight stale responses.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- QDEPTH, 2: instruction FIFO entries; power of two, ≥2.
- MAX_OUT, 2: maximum imem requests in flight, including ones marked for discard.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  request valid.
- imem_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  in-order response valid.
- imem_rdata  in  32  response instruction.
- redirect  in  1  branch taken or PC write; one-cycle pulse.
- redirect_pc  in  32  new fetch address.
- stallD  in  1  decode stalled; do not pop.
- InstrF  out  32  head instruction; 32'h0 when empty.
- PCPlus4F  out  32  head entry's address + 4; 0 when empty.
- validF  out  1  FIFO non-empty.

Behaviour:
- Reset (async assert, state changes take effect on the next clk edge after release):
  - fpc=RESET_PC, FIFO empty, out_cnt=0, drop_cnt=0.
  - imem_req=0, validF=0, InstrF=0, PCPlus4F=0.
  - First request no earlier than the first clk edge after reset_n rises.
- Request:
  - imem_req = ~redirect & (out_cnt < MAX_OUT) & (count + (out_cnt − drop_cnt) < QDEPTH); imem_addr = fpc.
  - Handshake = imem_req & imem_gnt; on handshake, fpc <= fpc + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - imem_addr and imem_req must stay stable while req is high and gnt is low.
- out_cnt: +1 on handshake, −1 on imem_rvalid, unchanged when both occur together.
- Response:
  - imem_rvalid with drop_cnt>0: discard the data, drop_cnt−1.
  - Otherwise push {pc_of_resp+4, imem_rdata}. pc_of_resp comes from a small address shadow FIFO of depth MAX_OUT, written at handshake.
  - imem_rvalid with out_cnt==0 is a protocol violation: ignore it and fire a simulation assertion.
- Output:
  - Head entry drives InstrF/PCPlus4F combinationally; validF = ~empty.
  - Pop when validF & ~stallD & ~redirect.
- Latency: gnt at t, rvalid at t+k (k≥1), validF at t+k+1 if the FIFO was empty.
- Full FIFO: push and pop in the same cycle are legal. Overflow is impossible by credit; an overflow fires an assertion.
- Redirect cycle:
  - FIFO cleared, fpc <= redirect_pc, no request issued.
  - drop_cnt <= out_cnt − imem_rvalid; any response arriving in that same cycle is itself discarded.
  - Outputs in the redirect cycle are don't-care; the hazard unit flushes IF/ID.
  - Redirect beats stallD.
  - Redirect with drop_cnt already >0 accumulates the new count.
  - Back-to-back redirects: the last one wins.
- Requests to the new PC resume the cycle after redirect, even while drops are still pending, subject to MAX_OUT.
- Reset mid-operation: all counters cleared immediately. Any late imem_rvalid after reset violates the protocol; the memory must also be reset.

Test Plan:
- Reset release, gnt=1, fixed 1-cycle latency, rdata=0xE0000000+addr -> imem_addr 0,4,8,… on consecutive cycles; validF first high 2 cycles after the first gnt; PCPlus4F=4,8,12,… one per cycle.
- Steady stream, then stallD=1 for 5 cycles -> FIFO fills to QDEPTH; imem_req drops once count+live outstanding=2; InstrF holds; no instruction is lost or duplicated after release.
- Two requests in flight (addrs 0x10, 0x14), redirect to 0x100 -> both responses discarded; next imem_addr=0x100; first validF carries PCPlus4F=0x104.
- Redirect in the same cycle as an imem_rvalid of the last outstanding request -> response discarded; drop_cnt=0 afterwards; the 0x100 fetch proceeds with no extra drop.
- gnt held low 3 cycles -> imem_addr stays stable, fpc does not advance, then advances exactly once per grant.
- reset_n pulled low mid-stream between clk edges -> validF and imem_req go 0 immediately; after release, fetch restarts at RESET_PC with empty FIFO and out_cnt=0.
